axis_sample_packer: RTL and testbench

Packs a stream of narrow samples (one SAMPLE_WIDTH sample per beat) into full BUS_WIDTH words and presents them on an AXI-Stream master that feeds `axis_sync_fifo` directly. It sits between the sample source (ADC/DSP lane) and the capture FIFO on the same clock. It sustains one sample per cycle under no backpressure. A flush request emits a zero-padded partial word.

---
 rtl/axis_sample_packer.sv | 104 ++++++++++
 tb/tb_axis_sample_packer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sample_packer.sv
// Packs SAMPLE_WIDTH samples, lane 0 first, into BUS_WIDTH AXI-Stream words.
// A flush request emits the pending partial word with its unused lanes zeroed.
module axis_sample_packer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int BUS_WIDTH    = 256
) (
    input  logic                    axis_clk,
    input  logic                    rst,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [SAMPLE_WIDTH-1:0] s_axis_tdata,
    input  logic                    flush,
    output logic [BUS_WIDTH-1:0]    m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [31:0]             word_count,
    output logic [15:0]             partial_count
);
    localparam int R  = BUS_WIDTH / SAMPLE_WIDTH;
    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam logic [CW-1:0] LAST = CW'(R - 1);

    if ((R < 2) || ((R & (R - 1)) != 0) || (R * SAMPLE_WIDTH != BUS_WIDTH)) begin : g_bad_params
        $error("BUS_WIDTH must be a power-of-2 multiple (>=2) of SAMPLE_WIDTH");
    end

    logic [BUS_WIDTH-1:0] acc;
    logic [BUS_WIDTH-1:0] acc_wr;
    logic [CW-1:0]        cnt;
    logic                 flush_pend;
    logic                 run;

    logic accept;
    logic complete;
    logic out_free;
    logic m_hs;
    logic flush_load;
    logic flush_set;

    // Only the word-completing beat must wait for a held output word.
    assign s_axis_tready = run & ~flush_pend
                         & ~((cnt == LAST) & m_axis_tvalid & ~m_axis_tready);

    assign accept     = s_axis_tvalid & s_axis_tready;
    assign complete   = accept & (cnt == LAST);
    assign m_hs       = m_axis_tvalid & m_axis_tready;
    assign out_free   = ~m_axis_tvalid | m_axis_tready;
    assign flush_load = flush_pend & out_free;
    assign flush_set  = flush & ~flush_pend & ~complete & (accept | (cnt != '0));

    always_comb begin
        acc_wr = acc;
        acc_wr[cnt*SAMPLE_WIDTH +: SAMPLE_WIDTH] = s_axis_tdata;
    end

    always_ff @(posedge axis_clk or negedge rst) begin
        if (!rst) begin
            run           <= 1'b0;
            acc           <= '0;
            cnt           <= '0;
            flush_pend    <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            word_count    <= '0;
            partial_count <= '0;
        end else begin
            run <= 1'b1;

            if (m_hs) begin
                word_count <= word_count + 32'd1;
            end

            // Accept and flush_load are mutually exclusive: tready is low while pending.
            if (complete) begin
                m_axis_tdata  <= acc_wr;
                m_axis_tvalid <= 1'b1;
                acc           <= '0;
                cnt           <= '0;
            end else if (flush_load) begin
                m_axis_tdata  <= acc;
                m_axis_tvalid <= 1'b1;
                acc           <= '0;
                cnt           <= '0;
                flush_pend    <= 1'b0;
                if (partial_count != 16'hFFFF) begin
                    partial_count <= partial_count + 16'd1;
                end
            end else begin
                if (accept) begin
                    acc <= acc_wr;
                    cnt <= cnt + 1'b1;
                end
                if (m_hs) begin
                    m_axis_tvalid <= 1'b0;
                end
            end

            if (flush_set) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_sample_packer.sv
// Directed bench for axis_sample_packer with default 16-bit samples into 256-bit words.
module tb_axis_sample_packer;
    logic         axis_clk;
    logic         rst;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [15:0]  s_axis_tdata;
    logic         flush;
    logic [255:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [31:0]  word_count;
    logic [15:0]  partial_count;

    int n_vec = 0;
    int n_err = 0;

    axis_sample_packer #(.SAMPLE_WIDTH(16), .BUS_WIDTH(256)) dut (
        .axis_clk      (axis_clk),
        .rst           (rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .flush         (flush),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .word_count    (word_count),
        .partial_count (partial_count)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Lane i = base + i*step for lanes below n, zero above.
    function automatic logic [255:0] ramp(input logic [15:0] base, input logic [15:0] step, input int n);
        logic [255:0] w;
        w = '0;
        for (int i = 0; i < n; i++) begin
            w[i*16 +: 16] = 16'(base + 16'(i) * step);
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        flush         = 1'b0;
        m_axis_tready = 1'b1;
        rst           = 1'b0;
        #3;
        @(negedge axis_clk);
        rst = 1'b1;
        tick();
    endtask

    initial begin
        int stalls;
        int words;
        int acc_n;
        int hi;
        logic rdy;

        // Reset values
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        flush = 1'b0;
        m_axis_tready = 1'b1;
        #12;
        chk("rst_tvalid", 256'(m_axis_tvalid), 256'd0);
        chk("rst_tdata", m_axis_tdata, 256'd0);
        chk("rst_s_tready", 256'(s_axis_tready), 256'd0);
        chk("rst_wc", 256'(word_count), 256'd0);
        chk("rst_pc", 256'(partial_count), 256'd0);
        @(negedge axis_clk);
        rst = 1'b1;
        tick();
        chk("rst_release_tready", 256'(s_axis_tready), 256'd1);

        // One word from 0x0001..0x0010
        stalls = 0;
        for (int k = 0; k < 16; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 16'(k + 1);
            if (!s_axis_tready) stalls++;
            if (k == 15) chk("w1_not_early", 256'(m_axis_tvalid), 256'd0);
            tick();
        end
        s_axis_tvalid = 1'b0;
        chk("w1_tvalid", 256'(m_axis_tvalid), 256'd1);
        chk("w1_data", m_axis_tdata, ramp(16'h0001, 16'd1, 16));
        tick();
        chk("w1_tvalid_one_cycle", 256'(m_axis_tvalid), 256'd0);
        chk("w1_wc", 256'(word_count), 256'd1);
        chk("w1_stalls", 256'(stalls), 256'd0);

        // 64 continuous samples -> 4 words
        do_reset();
        stalls = 0;
        words = 0;
        for (int k = 0; k < 64; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 16'(k);
            if (!s_axis_tready) stalls++;
            tick();
            if (m_axis_tvalid) begin
                chk("s64_word_cycle", 256'(k + 1), 256'(16 * (words + 1)));
                chk("s64_word_data", m_axis_tdata, ramp(16'(16 * words), 16'd1, 16));
                words++;
            end
        end
        s_axis_tvalid = 1'b0;
        tick();
        chk("s64_words", 256'(words), 256'd4);
        chk("s64_stalls", 256'(stalls), 256'd0);
        chk("s64_wc", 256'(word_count), 256'd4);

        // Backpressure: 40 samples offered with downstream stalled
        do_reset();
        m_axis_tready = 1'b0;
        acc_n = 0;
        for (int k = 0; k < 40; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 16'(256 + acc_n);
            rdy = s_axis_tready;
            tick();
            if (rdy) acc_n++;
        end
        chk("bp_accepted", 256'(acc_n), 256'd31);
        chk("bp_s_tready_low", 256'(s_axis_tready), 256'd0);
        chk("bp_held_valid", 256'(m_axis_tvalid), 256'd1);
        chk("bp_held_data", m_axis_tdata, ramp(16'h0100, 16'd1, 16));
        chk("bp_wc_held", 256'(word_count), 256'd0);
        m_axis_tready = 1'b1;
        s_axis_tdata  = 16'(256 + acc_n);
        #1;
        chk("bp_release_tready", 256'(s_axis_tready), 256'd1);
        tick();
        chk("bp_w2_valid", 256'(m_axis_tvalid), 256'd1);
        chk("bp_w2_data", m_axis_tdata, ramp(16'h0110, 16'd1, 16));
        chk("bp_wc1", 256'(word_count), 256'd1);
        s_axis_tvalid = 1'b0;
        tick();
        chk("bp_w2_gone", 256'(m_axis_tvalid), 256'd0);
        chk("bp_wc2", 256'(word_count), 256'd2);

        // 5 x 0xAAAA then flush -> partial word
        do_reset();
        for (int k = 0; k < 5; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 16'hAAAA;
            tick();
        end
        s_axis_tvalid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_pend_tvalid", 256'(m_axis_tvalid), 256'd0);
        chk("fl_pend_s_tready", 256'(s_axis_tready), 256'd0);
        tick();
        chk("fl_tvalid", 256'(m_axis_tvalid), 256'd1);
        chk("fl_data", m_axis_tdata, ramp(16'hAAAA, 16'd0, 5));
        chk("fl_pc", 256'(partial_count), 256'd1);
        tick();
        chk("fl_wc", 256'(word_count), 256'd1);
        chk("fl_tready_back", 256'(s_axis_tready), 256'd1);
        // cnt must be back at 0: next full word starts at lane 0
        for (int k = 0; k < 16; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 16'(16'h0200 + k);
            tick();
        end
        s_axis_tvalid = 1'b0;
        chk("fl_next_word", m_axis_tdata, ramp(16'h0200, 16'd1, 16));

        // Flush with nothing pending
        do_reset();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        hi = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (m_axis_tvalid) hi++;
        end
        chk("fl0_no_word", 256'(hi), 256'd0);
        chk("fl0_pc", 256'(partial_count), 256'd0);
        chk("fl0_tready", 256'(s_axis_tready), 256'd1);

        // Flush on the word-completing beat
        do_reset();
        hi = 0;
        for (int k = 0; k < 16; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 16'(16'h0300 + k);
            flush = (k == 15);
            tick();
            if (m_axis_tvalid) hi++;
        end
        s_axis_tvalid = 1'b0;
        flush = 1'b0;
        chk("fl16_data", m_axis_tdata, ramp(16'h0300, 16'd1, 16));
        for (int k = 0; k < 4; k++) begin
            tick();
            if (m_axis_tvalid) hi++;
        end
        chk("fl16_one_word", 256'(hi), 256'd1);
        chk("fl16_pc", 256'(partial_count), 256'd0);
        chk("fl16_wc", 256'(word_count), 256'd1);

        // Repeated flush while pending -> a single partial word
        do_reset();
        for (int k = 0; k < 3; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 16'(16'h0400 + k);
            tick();
        end
        s_axis_tvalid = 1'b0;
        hi = 0;
        for (int k = 0; k < 8; k++) begin
            flush = (k < 3);
            tick();
            if (m_axis_tvalid) begin
                hi++;
                chk("flrep_data", m_axis_tdata, ramp(16'h0400, 16'd1, 3));
            end
        end
        flush = 1'b0;
        chk("flrep_one_word", 256'(hi), 256'd1);
        chk("flrep_pc", 256'(partial_count), 256'd1);
        chk("flrep_wc", 256'(word_count), 256'd1);

        // Reset with a held word and 7 partial samples
        do_reset();
        m_axis_tready = 1'b0;
        for (int k = 0; k < 23; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 16'(16'h0500 + k);
            tick();
        end
        chk("mr_held_before", 256'(m_axis_tvalid), 256'd1);
        rst = 1'b0;
        #1;
        chk("mr_tvalid_drop", 256'(m_axis_tvalid), 256'd0);
        chk("mr_tdata_zero", m_axis_tdata, 256'd0);
        chk("mr_wc", 256'(word_count), 256'd0);
        chk("mr_pc", 256'(partial_count), 256'd0);
        chk("mr_s_tready", 256'(s_axis_tready), 256'd0);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge axis_clk);
        rst = 1'b1;
        hi = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (m_axis_tvalid) hi++;
        end
        chk("mr_no_word", 256'(hi), 256'd0);
        for (int k = 0; k < 16; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 16'(16'h0600 + k);
            tick();
        end
        s_axis_tvalid = 1'b0;
        chk("mr_clean_valid", 256'(m_axis_tvalid), 256'd1);
        chk("mr_clean_data", m_axis_tdata, ramp(16'h0600, 16'd1, 16));
        tick();
        chk("mr_clean_wc", 256'(word_count), 256'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
